// File: rtl/me_lfsr_multi.sv
// Multi-channel Fibonacci LFSR random source with seed load, lock-up recovery and strided channel bit maps.
// Optional period monitor enabled by defining LFSR_PERIOD_MON_EN.
module me_lfsr_multi #(
    parameter int                WIDTH        = 16,
    parameter logic [WIDTH-1:0]  TAPS         = 16'h8016,
    parameter int                NCH          = 4,
    parameter int                OUT_W        = 4,
    parameter int                STRIDE       = 7,
    parameter logic [WIDTH-1:0]  DEFAULT_SEED = 16'hACE1
) (
    input  logic                   TRIG,
    input  logic                   RESET,
    input  logic                   EN,
    input  logic                   LOAD,
    input  logic [WIDTH-1:0]       SEED,
    output logic [NCH*OUT_W-1:0]   OUT,
    output logic                   VALID,
    output logic                   LOCKUP
`ifdef LFSR_PERIOD_MON_EN
    ,
    output logic                   PERIOD_DONE,
    output logic [WIDTH-1:0]       PERIOD_CNT
`endif
);

    localparam int NB = NCH * OUT_W;

    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] d_next;
    logic [WIDTH-1:0] seed_eff;
    logic [NB-1:0]    mapped;
    logic             fb;
    logic             seed_load;
    logic             lock;

    assign fb        = ^(d & TAPS);
    assign d_next    = {d[WIDTH-2:0], fb};
    assign seed_eff  = (SEED == '0) ? DEFAULT_SEED : SEED;
    assign seed_load = RESET | LOAD;
    assign lock      = (d == '0);

    // Output bit k picks state bit (k*STRIDE) mod WIDTH; indices may repeat when NB > WIDTH.
    for (genvar k = 0; k < NB; k++) begin : g_map
        localparam int IDX = (k * STRIDE) % WIDTH;
        assign mapped[k] = d[IDX];
    end

    always_ff @(posedge TRIG) begin
        if (seed_load) begin
            d      <= seed_eff;
            OUT    <= '0;
            VALID  <= 1'b0;
            LOCKUP <= 1'b0;
        end else if (EN) begin
            if (lock) begin
                d      <= DEFAULT_SEED;
                OUT    <= '0;
                LOCKUP <= 1'b1;
            end else begin
                OUT    <= mapped;
                d      <= d_next;
                VALID  <= 1'b1;
                LOCKUP <= 1'b0;
            end
        end else begin
            LOCKUP <= 1'b0;
        end
    end

`ifdef LFSR_PERIOD_MON_EN
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] pcnt;

    // A period completes when a step returns the state to the last seed written.
    always_ff @(posedge TRIG) begin
        if (seed_load) begin
            s           <= seed_eff;
            pcnt        <= '0;
            PERIOD_DONE <= 1'b0;
            PERIOD_CNT  <= '0;
        end else if (EN) begin
            if (lock) begin
                s           <= DEFAULT_SEED;
                pcnt        <= '0;
                PERIOD_DONE <= 1'b0;
            end else if (d_next == s) begin
                pcnt        <= '0;
                PERIOD_DONE <= 1'b1;
                PERIOD_CNT  <= pcnt + 1'b1;
            end else begin
                pcnt        <= pcnt + 1'b1;
                PERIOD_DONE <= 1'b0;
            end
        end else begin
            PERIOD_DONE <= 1'b0;
        end
    end
`endif

endmodule
